// File: rtl/pic_pkg.sv
// Shared constants and state encoding for the PIC interrupt-acknowledge logic.
package pic_pkg;

  localparam int unsigned NIRQ_DFLT    = 8;
  localparam int unsigned SPUR_ID_DFLT = 7;
  localparam int unsigned ID_W         = 3;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait1 = 3'd1,
    StAck1  = 3'd2,
    StGap   = 3'd3,
    StAck2  = 3'd4
  } state_e;

endpackage

// File: rtl/isr_eoi_dec.sv
// Combinational EOI decoder: turns an EOI command into the ISR bits it clears.
module isr_eoi_dec
  import pic_pkg::*;
#(
  parameter int unsigned NIRQ = NIRQ_DFLT
) (
  input  logic [NIRQ-1:0] i_isr,
  input  logic            i_eoi,
  input  logic            i_eoi_sl,
  input  logic [ID_W-1:0] i_eoi_lvl,
  output logic [NIRQ-1:0] o_clr
);

  localparam logic [NIRQ-1:0] ONE = NIRQ'(1);

  logic [NIRQ-1:0] w_lowest;

  // Scan from the top down so the last hit is the highest-priority (lowest) bit.
  always_comb begin
    w_lowest = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (i_isr[i]) begin
        w_lowest = ONE << i;
      end
    end
  end

  always_comb begin
    o_clr = '0;
    if (i_eoi) begin
      if (i_eoi_sl) begin
        o_clr = ONE << i_eoi_lvl;
      end else begin
        o_clr = w_lowest;
      end
    end
  end

endmodule

// File: rtl/inta_seq.sv
// CPU-side interrupt responder: raises int_out, runs the two-pulse INTA cycle
// and keeps the in-service register up to date (AEOI, specific, non-specific EOI).
module inta_seq
  import pic_pkg::*;
#(
  parameter int unsigned NIRQ    = NIRQ_DFLT,
  parameter int unsigned SPUR_ID = SPUR_ID_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            isprior,
  input  logic [ID_W-1:0] irq_id,
  input  logic            inta,
  input  logic            ar,
  input  logic [4:0]      vec_base,
  input  logic            eoi,
  input  logic            eoi_sl,
  input  logic [ID_W-1:0] eoi_lvl,
  output logic            int_out,
  output logic [NIRQ-1:0] isr,
  output logic [NIRQ-1:0] irr_clr,
  output logic [7:0]      dout,
  output logic            dout_en
);

  localparam logic [NIRQ-1:0] ONE = NIRQ'(1);

  state_e          r_state, w_state_d;
  logic            r_inta_q;
  logic            r_int_out, w_int_out_d;
  logic [NIRQ-1:0] r_isr, w_isr_d;
  logic [NIRQ-1:0] r_irr_clr, w_irr_clr_d;
  logic [7:0]      r_dout, w_dout_d;
  logic            r_dout_en, w_dout_en_d;
  logic [ID_W-1:0] r_id_lat, w_id_lat_d;
  logic            r_spur, w_spur_d;

  logic            w_rise, w_fall;
  logic [NIRQ-1:0] w_set, w_aeoi_clr, w_eoi_clr;

  assign w_rise = inta & ~r_inta_q;
  assign w_fall = ~inta & r_inta_q;

  isr_eoi_dec #(
    .NIRQ (NIRQ)
  ) u_eoi_dec (
    .i_isr     (r_isr),
    .i_eoi     (eoi),
    .i_eoi_sl  (eoi_sl),
    .i_eoi_lvl (eoi_lvl),
    .o_clr     (w_eoi_clr)
  );

  always_comb begin
    w_state_d   = r_state;
    w_int_out_d = 1'b0;
    w_dout_d    = r_dout;
    w_dout_en_d = 1'b0;
    w_id_lat_d  = r_id_lat;
    w_spur_d    = r_spur;
    w_set       = '0;
    w_aeoi_clr  = '0;
    unique case (r_state)
      StIdle: begin
        if (isprior) begin
          w_state_d   = StWait1;
          w_int_out_d = 1'b1;
        end
      end
      StWait1: begin
        w_int_out_d = 1'b1;
        if (w_rise) begin
          w_state_d   = StAck1;
          w_int_out_d = 1'b0;
          // A request that vanished before the first pulse becomes spurious.
          if (isprior) begin
            w_id_lat_d = irq_id;
            w_spur_d   = 1'b0;
            w_set      = ONE << irq_id;
          end else begin
            w_id_lat_d = ID_W'(SPUR_ID);
            w_spur_d   = 1'b1;
          end
        end
      end
      StAck1: begin
        if (w_fall) begin
          w_state_d = StGap;
        end
      end
      StGap: begin
        if (w_rise) begin
          w_state_d   = StAck2;
          w_dout_d    = {vec_base, r_id_lat};
          w_dout_en_d = 1'b1;
        end
      end
      StAck2: begin
        w_dout_en_d = 1'b1;
        if (w_fall) begin
          w_state_d   = StIdle;
          w_dout_en_d = 1'b0;
          w_dout_d    = '0;
          if (ar && !r_spur) begin
            w_aeoi_clr = ONE << r_id_lat;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_irr_clr_d = w_set;
  // Set after clear so a same-bit collision leaves the bit in service.
  assign w_isr_d = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_inta_q  <= 1'b0;
      r_int_out <= 1'b0;
      r_isr     <= '0;
      r_irr_clr <= '0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
      r_id_lat  <= '0;
      r_spur    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_inta_q  <= inta;
      r_int_out <= w_int_out_d;
      r_isr     <= w_isr_d;
      r_irr_clr <= w_irr_clr_d;
      r_dout    <= w_dout_d;
      r_dout_en <= w_dout_en_d;
      r_id_lat  <= w_id_lat_d;
      r_spur    <= w_spur_d;
    end
  end

  assign int_out = r_int_out;
  assign isr     = r_isr;
  assign irr_clr = r_irr_clr;
  assign dout    = r_dout;
  assign dout_en = r_dout_en;

endmodule

// File: tb/tb_inta_seq.sv
// Scoreboard bench for inta_seq: each driven cycle queues the outputs expected
// after the next clock edge; the queue is drained and compared just after that edge.
module tb_inta_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       isprior;
  logic [2:0] irq_id;
  logic       inta;
  logic       ar;
  logic [4:0] vec_base;
  logic       eoi;
  logic       eoi_sl;
  logic [2:0] eoi_lvl;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] irr_clr;
  logic [7:0] dout;
  logic       dout_en;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic       e_int;
    logic [7:0] e_isr;
    logic [7:0] e_irr;
    logic [7:0] e_dout;
    logic       e_den;
  } exp_t;

  exp_t sb_q[$];

  inta_seq #(
    .NIRQ    (8),
    .SPUR_ID (7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .isprior  (isprior),
    .irq_id   (irq_id),
    .inta     (inta),
    .ar       (ar),
    .vec_base (vec_base),
    .eoi      (eoi),
    .eoi_sl   (eoi_sl),
    .eoi_lvl  (eoi_lvl),
    .int_out  (int_out),
    .isr      (isr),
    .irr_clr  (irr_clr),
    .dout     (dout),
    .dout_en  (dout_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h", tag, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".int_out"}, {7'd0, int_out}, {7'd0, e.e_int});
      check({e.tag, ".isr"}, isr, e.e_isr);
      check({e.tag, ".irr_clr"}, irr_clr, e.e_irr);
      check({e.tag, ".dout"}, dout, e.e_dout);
      check({e.tag, ".dout_en"}, {7'd0, dout_en}, {7'd0, e.e_den});
    end
  endtask

  task automatic cyc(input string tag, input logic e_int, input logic [7:0] e_isr,
                     input logic [7:0] e_irr, input logic [7:0] e_dout, input logic e_den);
    exp_t e;
    e.tag    = tag;
    e.e_int  = e_int;
    e.e_isr  = e_isr;
    e.e_irr  = e_irr;
    e.e_dout = e_dout;
    e.e_den  = e_den;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst     = 1'b1;
    isprior = 1'b0;
    irq_id  = 3'd0;
    inta    = 1'b0;
    eoi     = 1'b0;
    eoi_sl  = 1'b0;
    eoi_lvl = 3'd0;
    cyc(tag, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic eoi_cmd(input string tag, input logic sl, input logic [2:0] lvl,
                         input logic [7:0] e_isr);
    eoi     = 1'b1;
    eoi_sl  = sl;
    eoi_lvl = lvl;
    cyc(tag, 1'b0, e_isr, 8'h00, 8'h00, 1'b0);
    eoi = 1'b0;
  endtask

  // Full request + two-pulse acknowledge; an optional EOI lands on the first rise.
  task automatic do_ack(input string tag, input logic spur, input logic [2:0] id,
                        input logic [7:0] isr0, input logic [7:0] isr1,
                        input logic [7:0] isr_end, input logic ce, input logic csl,
                        input logic [2:0] clvl);
    logic [7:0] irr;
    logic [7:0] dv;
    irr = spur ? 8'h00 : (8'h01 << id);
    dv  = {vec_base, spur ? 3'd7 : id};
    isprior = 1'b1;
    irq_id  = id;
    inta    = 1'b0;
    cyc({tag, ".req"}, 1'b1, isr0, 8'h00, 8'h00, 1'b0);
    if (spur) isprior = 1'b0;
    cyc({tag, ".wait"}, 1'b1, isr0, 8'h00, 8'h00, 1'b0);
    inta    = 1'b1;
    eoi     = ce;
    eoi_sl  = csl;
    eoi_lvl = clvl;
    cyc({tag, ".rise1"}, 1'b0, isr1, irr, 8'h00, 1'b0);
    isprior = 1'b0;
    eoi     = 1'b0;
    cyc({tag, ".hi1"}, 1'b0, isr1, 8'h00, 8'h00, 1'b0);
    inta = 1'b0;
    cyc({tag, ".fall1"}, 1'b0, isr1, 8'h00, 8'h00, 1'b0);
    cyc({tag, ".gap"}, 1'b0, isr1, 8'h00, 8'h00, 1'b0);
    inta = 1'b1;
    cyc({tag, ".rise2"}, 1'b0, isr1, 8'h00, dv, 1'b1);
    cyc({tag, ".hi2"}, 1'b0, isr1, 8'h00, dv, 1'b1);
    inta = 1'b0;
    cyc({tag, ".fall2"}, 1'b0, isr_end, 8'h00, 8'h00, 1'b0);
    cyc({tag, ".idle"}, 1'b0, isr_end, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    ar       = 1'b0;
    vec_base = 5'b01000;

    // Normal acknowledge of level 3: vector 8'h43, ISR bit 3 stays set.
    do_reset("rst0");
    do_ack("norm", 1'b0, 3'd3, 8'h00, 8'h08, 8'h08, 1'b0, 1'b0, 3'd0);

    // AEOI: ISR bit drops after the second pulse.
    do_reset("rst1");
    ar = 1'b1;
    do_ack("aeoi", 1'b0, 3'd3, 8'h00, 8'h08, 8'h00, 1'b0, 1'b0, 3'd0);
    ar = 1'b0;

    // Spurious: request drops before the first pulse.
    do_reset("rst2");
    do_ack("spur", 1'b1, 3'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);

    // Build ISR = 8'hA4, then exercise both EOI flavours.
    do_reset("rst3");
    do_ack("ns_a2", 1'b0, 3'd2, 8'h00, 8'h04, 8'h04, 1'b0, 1'b0, 3'd0);
    do_ack("ns_a5", 1'b0, 3'd5, 8'h04, 8'h24, 8'h24, 1'b0, 1'b0, 3'd0);
    do_ack("ns_a7", 1'b0, 3'd7, 8'h24, 8'hA4, 8'hA4, 1'b0, 1'b0, 3'd0);
    eoi_cmd("nseoi", 1'b0, 3'd0, 8'hA0);
    eoi_cmd("seoi7", 1'b1, 3'd7, 8'h20);
    eoi_cmd("seoi7_nop", 1'b1, 3'd7, 8'h20);
    eoi_cmd("nseoi5", 1'b0, 3'd0, 8'h00);
    eoi_cmd("nseoi_empty", 1'b0, 3'd0, 8'h00);

    // Collisions between INTA1 set and EOI clear.
    do_reset("rst4");
    do_ack("c_pre5", 1'b0, 3'd5, 8'h00, 8'h20, 8'h20, 1'b0, 1'b0, 3'd0);
    do_ack("c_spec", 1'b0, 3'd2, 8'h20, 8'h24, 8'h24, 1'b1, 1'b1, 3'd2);
    eoi_cmd("c_clr2", 1'b0, 3'd0, 8'h20);
    do_ack("c_pre3", 1'b0, 3'd3, 8'h20, 8'h28, 8'h28, 1'b0, 1'b0, 3'd0);
    do_ack("c_nspec", 1'b0, 3'd2, 8'h28, 8'h24, 8'h24, 1'b1, 1'b0, 3'd0);

    // Reset while in GAP abandons the acknowledge; later pulses are ignored.
    do_reset("rst5");
    isprior = 1'b1;
    irq_id  = 3'd4;
    cyc("mr.req", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    cyc("mr.wait", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    inta = 1'b1;
    cyc("mr.rise1", 1'b0, 8'h10, 8'h10, 8'h00, 1'b0);
    isprior = 1'b0;
    cyc("mr.hi1", 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
    inta = 1'b0;
    cyc("mr.gap", 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    cyc("mr.rst", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    rst  = 1'b0;
    inta = 1'b1;
    cyc("mr.idle_rise", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    cyc("mr.idle_hi", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    inta = 1'b0;
    cyc("mr.idle_fall", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inta_seq.md
Name: inta_seq

Overview:
- CPU-facing responder for the interrupt request raised by the PIC priority resolver.
- Turns the resolver's request (`isprior`) into `int_out` to the CPU.
- Runs the two-pulse INTA acknowledge cycle: freezes the winning level, sets the ISR, clears the edge-latched IRR bit, drives the vector byte.
- Owns ISR bookkeeping for automatic EOI (AEOI), non-specific EOI and specific EOI.

Parameters:
- NIRQ, 8, number of interrupt levels; also the ISR width. Level 0 has the highest priority.
- SPUR_ID, 7, level ID returned when the request vanishes before the first INTA pulse (spurious interrupt).

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- isprior  in  1  request from the priority resolver (a pending, unmasked level outranks the current ISR).
- irq_id  in  3  index of the winning level from the resolver; valid while isprior=1.
- inta  in  1  CPU interrupt-acknowledge level, active high, synchronous to clk. One pulse = one or more high cycles.
- ar  in  1  AEOI enable (from the ICW4 register).
- vec_base  in  5  vector bits T7..T3 (from the ICW2 register).
- eoi  in  1  one-cycle EOI command strobe.
- eoi_sl  in  1  qualifies eoi: 1 = specific EOI, 0 = non-specific.
- eoi_lvl  in  3  level to clear on a specific EOI.
- int_out  out  1  interrupt request to the CPU.
- isr  out  NIRQ  in-service register.
- irr_clr  out  NIRQ  one-hot, one-cycle pulse that clears the acknowledged IRR bit.
- dout  out  8  vector byte.
- dout_en  out  1  enable for the data-bus driver.

Behaviour:
- Reset (synchronous, active high): state=IDLE; int_out=0; isr=0; irr_clr=0; dout=0; dout_en=0; id_lat=0; spur=0; inta_q=0. A reset mid-cycle abandons the acknowledge with no ISR update.
- Edge detect: inta_q is the registered copy of inta.
  - rise = inta & ~inta_q
  - fall = ~inta & inta_q
- States:
  - IDLE: when isprior=1 -> WAIT1. int_out=1 from the next cycle (1-cycle latency).
  - WAIT1: int_out stays high even if isprior drops. On rise -> ACK1, with:
    - if isprior=1: id_lat=irq_id, spur=0, isr[irq_id] set next cycle, irr_clr one-hot on irq_id for exactly one cycle;
    - if isprior=0: id_lat=SPUR_ID, spur=1, no ISR or IRR change;
    - int_out=0 from the cycle after rise.
  - ACK1: dout_en=0. On fall -> GAP.
  - GAP: on rise -> ACK2. dout={vec_base,id_lat} and dout_en=1 from the cycle after rise.
  - ACK2: dout_en stays 1 while inta is high. On fall:
    - dout_en=0 and dout=0 next cycle;
    - if ar=1 and spur=0, clear isr[id_lat];
    - -> IDLE.
- Back-to-back requests: IDLE re-evaluates isprior in the cycle after the return.
- inta rise while in IDLE: ignored. dout_en stays 0.
- EOI handling (accepted in any state):
  - non-specific (eoi=1, eoi_sl=0): clears the lowest-index set ISR bit; no effect when isr=0.
  - specific (eoi=1, eoi_sl=1): clears isr[eoi_lvl]; no effect if that bit is already 0.
- Same-cycle ISR set and clear:
  - same bit: the set wins, so the bit ends 1;
  - different bits: both are applied.
  - The non-specific EOI search uses the pre-update isr value.
- AEOI clear coinciding with an EOI: the union of both clear masks is applied.
- int_out, isr, irr_clr, dout and dout_en are all registered outputs.

Decomposition:
- Package pic_pkg holds:
  - NIRQ and SPUR_ID defaults;
  - the ID width constant (3);
  - the state encoding: IDLE=0, WAIT1=1, ACK1=2, GAP=3, ACK2=4, in a 3-bit localparam set.
- Sub-module isr_eoi_dec (combinational): maps isr, eoi, eoi_sl and eoi_lvl to an NIRQ-bit clear mask. It contains the lowest-set-bit finder. It is also reused by the resolver bench.

Test Plan:
- Normal acknowledge: reset; vec_base=5'b01000; isprior=1, irq_id=3; two INTA pulses, each 2 cycles high with a 2-cycle gap. Required:
  - int_out=1 one cycle after isprior;
  - irr_clr=8'b00001000 for one cycle;
  - isr=8'b00001000;
  - during the 2nd pulse, dout=8'h43 with dout_en=1;
  - int_out=0 after the 1st rise.
- AEOI: same stimulus as above with ar=1 -> isr returns to 0 the cycle after the 2nd-pulse fall.
- Spurious: isprior pulses high, then low before INTA -> irr_clr stays 0, isr unchanged, 2nd-pulse dout={vec_base,3'b111}.
- Non-specific EOI: set isr=8'b10100100 through three acknowledges; eoi=1, eoi_sl=0 -> isr=8'b10100000. Specific EOI with eoi_lvl=7 -> isr=8'b00100000.
- Collision: EOI specific for level 2 in the same cycle that isr[2] is set by INTA1 -> isr[2]=1. A non-specific EOI in the same cycle clears the previous lowest bit, not bit 2.
- Reset mid-cycle: rst asserted in GAP -> next cycle all outputs are 0 and state is IDLE; a subsequent INTA pulse produces dout_en=0.
